// File: rtl/axi4_slave_pkg.sv
// Shared constants and FSM state types for the AXI4 slave memory model.
package axi4_slave_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] WRAP   = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Per-channel burst tracker: current word index, beat counter and last-beat flag.
module axi4_burst_addr_gen
  import axi4_slave_pkg::*;
#(
  parameter int WORD_BITS = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [WORD_BITS-1:0] start_word,
  input  logic [7:0]           len,
  input  logic [1:0]           burst,
  input  logic                 step,
  output logic [WORD_BITS-1:0] word,
  output logic                 last
);

  logic [WORD_BITS-1:0] word_r;
  logic [7:0]           len_r;
  logic [7:0]           cnt_r;
  logic                 fixed_r;

  // Capture burst context on accept; advance count and address on each beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_r  <= '0;
      len_r   <= 8'd0;
      cnt_r   <= 8'd0;
      fixed_r <= 1'b0;
    end else if (load) begin
      word_r  <= start_word;
      len_r   <= len;
      cnt_r   <= 8'd0;
      fixed_r <= (burst == FIXED);
    end else if (step) begin
      cnt_r <= cnt_r + 8'd1;
      // WRAP and the reserved encoding both behave as INCR; the word index wraps at RAM size
      if (!fixed_r) begin
        word_r <= word_r + WORD_BITS'(1);
      end
    end
  end

  assign word = word_r;
  assign last = (cnt_r == len_r);

endmodule

// File: rtl/axi4_slave_mem_model.sv
// AXI4 slave backed by a word-addressed RAM; independent write and read FSMs.
// Optional macro AXI_SLAVE_RSTALL_EN inserts an idle cycle after every read beat.
module axi4_slave_mem_model
  import axi4_slave_pkg::*;
#(
  parameter int MEM_ADDR_BITS = 14
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        M_AXI_AWID,
  input  logic [31:0] M_AXI_AWADDR,
  input  logic [7:0]  M_AXI_AWLEN,
  input  logic [2:0]  M_AXI_AWSIZE,
  input  logic [1:0]  M_AXI_AWBURST,
  input  logic        M_AXI_AWLOCK,
  input  logic [3:0]  M_AXI_AWCACHE,
  input  logic [2:0]  M_AXI_AWPROT,
  input  logic [3:0]  M_AXI_AWQOS,
  input  logic        M_AXI_AWUSER,
  input  logic        M_AXI_AWVALID,
  output logic        M_AXI_AWREADY,
  input  logic [31:0] M_AXI_WDATA,
  input  logic [3:0]  M_AXI_WSTRB,
  input  logic        M_AXI_WLAST,
  input  logic        M_AXI_WUSER,
  input  logic        M_AXI_WVALID,
  output logic        M_AXI_WREADY,
  output logic        M_AXI_BID,
  output logic [1:0]  M_AXI_BRESP,
  output logic        M_AXI_BUSER,
  output logic        M_AXI_BVALID,
  input  logic        M_AXI_BREADY,
  input  logic        M_AXI_ARID,
  input  logic [31:0] M_AXI_ARADDR,
  input  logic [7:0]  M_AXI_ARLEN,
  input  logic [2:0]  M_AXI_ARSIZE,
  input  logic [1:0]  M_AXI_ARBURST,
  input  logic [1:0]  M_AXI_ARLOCK,
  input  logic [3:0]  M_AXI_ARCACHE,
  input  logic [2:0]  M_AXI_ARPROT,
  input  logic [3:0]  M_AXI_ARQOS,
  input  logic        M_AXI_ARUSER,
  input  logic        M_AXI_ARVALID,
  output logic        M_AXI_ARREADY,
  output logic        M_AXI_RID,
  output logic [31:0] M_AXI_RDATA,
  output logic [1:0]  M_AXI_RRESP,
  output logic        M_AXI_RLAST,
  output logic        M_AXI_RUSER,
  output logic        M_AXI_RVALID,
  input  logic        M_AXI_RREADY
);

  localparam int WORD_BITS = MEM_ADDR_BITS - 2;
  localparam int DEPTH     = 1 << WORD_BITS;

  logic [31:0] mem [0:DEPTH-1];

  wr_state_e w_state_r, w_next_s;
  rd_state_e r_state_r, r_next_s;

  logic awready_r, wready_r, bvalid_r, bid_r, berr_r;
  logic arready_r, rvalid_r, rid_r, rvalid_next_s;
  logic aw_fire_s, w_fire_s, ar_fire_s, r_fire_s;
  logic w_last_s, r_last_s;
  logic [WORD_BITS-1:0] w_word_s, r_word_s;

  assign aw_fire_s = M_AXI_AWVALID & awready_r;
  assign w_fire_s  = M_AXI_WVALID & wready_r;
  assign ar_fire_s = M_AXI_ARVALID & arready_r;
  assign r_fire_s  = rvalid_r & M_AXI_RREADY;

  axi4_burst_addr_gen #(.WORD_BITS(WORD_BITS)) u_wr_addr (
    .clk        (ACLK),
    .rst_n      (ARESETN),
    .load       (aw_fire_s),
    .start_word (M_AXI_AWADDR[MEM_ADDR_BITS-1:2]),
    .len        (M_AXI_AWLEN),
    .burst      (M_AXI_AWBURST),
    .step       (w_fire_s),
    .word       (w_word_s),
    .last       (w_last_s)
  );

  axi4_burst_addr_gen #(.WORD_BITS(WORD_BITS)) u_rd_addr (
    .clk        (ACLK),
    .rst_n      (ARESETN),
    .load       (ar_fire_s),
    .start_word (M_AXI_ARADDR[MEM_ADDR_BITS-1:2]),
    .len        (M_AXI_ARLEN),
    .burst      (M_AXI_ARBURST),
    .step       (r_fire_s),
    .word       (r_word_s),
    .last       (r_last_s)
  );

  // Write FSM next state
  always_comb begin
    w_next_s = w_state_r;
    case (w_state_r)
      W_IDLE: if (aw_fire_s) w_next_s = W_DATA; else w_next_s = W_IDLE;
      W_DATA: if (w_fire_s && w_last_s) w_next_s = W_RESP; else w_next_s = W_DATA;
      W_RESP: if (bvalid_r && M_AXI_BREADY) w_next_s = W_IDLE; else w_next_s = W_RESP;
      default: w_next_s = W_IDLE;
    endcase
  end

  // Write FSM state, registered handshake outputs and error tracking
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state_r <= W_IDLE;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bid_r     <= 1'b0;
      berr_r    <= 1'b0;
    end else begin
      w_state_r <= w_next_s;
      awready_r <= (w_next_s == W_IDLE);
      wready_r  <= (w_next_s == W_DATA);
      bvalid_r  <= (w_next_s == W_RESP);
      if (aw_fire_s) begin
        bid_r  <= M_AXI_AWID;
        berr_r <= 1'b0;
      end else if (w_fire_s && (M_AXI_WLAST != w_last_s)) begin
        berr_r <= 1'b1;
      end
    end
  end

  // RAM byte-lane write; contents deliberately survive reset
  always_ff @(posedge ACLK) begin
    if (w_fire_s) begin
      for (int i = 0; i < 4; i++) begin
        if (M_AXI_WSTRB[i]) begin
          mem[w_word_s][8*i +: 8] <= M_AXI_WDATA[8*i +: 8];
        end
      end
    end
  end

  // Read FSM next state
  always_comb begin
    r_next_s = r_state_r;
    case (r_state_r)
      R_IDLE: if (ar_fire_s) r_next_s = R_DATA; else r_next_s = R_IDLE;
      R_DATA: if (r_fire_s && r_last_s) r_next_s = R_IDLE; else r_next_s = R_DATA;
      default: r_next_s = R_IDLE;
    endcase
  end

`ifdef AXI_SLAVE_RSTALL_EN
  assign rvalid_next_s = (r_next_s == R_DATA) && !r_fire_s;
`else
  assign rvalid_next_s = (r_next_s == R_DATA);
`endif

  // Read FSM state and registered handshake outputs
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state_r <= R_IDLE;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rid_r     <= 1'b0;
    end else begin
      r_state_r <= r_next_s;
      arready_r <= (r_next_s == R_IDLE);
      rvalid_r  <= rvalid_next_s;
      if (ar_fire_s) begin
        rid_r <= M_AXI_ARID;
      end
    end
  end

  assign M_AXI_AWREADY = awready_r;
  assign M_AXI_WREADY  = wready_r;
  assign M_AXI_BVALID  = bvalid_r;
  assign M_AXI_BID     = bid_r;
  assign M_AXI_BRESP   = berr_r ? SLVERR : OKAY;
  assign M_AXI_BUSER   = 1'b0;

  // Read data is a combinational RAM lookup so a same-cycle write is seen only on later beats
  assign M_AXI_ARREADY = arready_r;
  assign M_AXI_RVALID  = rvalid_r;
  assign M_AXI_RID     = rid_r;
  assign M_AXI_RDATA   = rvalid_r ? mem[r_word_s] : 32'h0000_0000;
  assign M_AXI_RRESP   = OKAY;
  assign M_AXI_RLAST   = rvalid_r & r_last_s;
  assign M_AXI_RUSER   = 1'b0;

  logic unused_s;
  assign unused_s = ^{M_AXI_AWADDR[31:MEM_ADDR_BITS], M_AXI_AWADDR[1:0], M_AXI_AWSIZE,
                      M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_AWUSER,
                      M_AXI_WUSER, M_AXI_ARADDR[31:MEM_ADDR_BITS], M_AXI_ARADDR[1:0],
                      M_AXI_ARSIZE, M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS,
                      M_AXI_ARUSER};

endmodule

// File: tb/tb_axi4_slave_mem_model.sv
// Scoreboard bench for axi4_slave_mem_model: stimulus queues expected B/R responses, a monitor checks them.
module tb_axi4_slave_mem_model;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        M_AXI_AWID = 1'b0;
  logic [31:0] M_AXI_AWADDR = 32'h0;
  logic [7:0]  M_AXI_AWLEN = 8'h0;
  logic [2:0]  M_AXI_AWSIZE = 3'd2;
  logic [1:0]  M_AXI_AWBURST = 2'b01;
  logic        M_AXI_AWLOCK = 1'b0;
  logic [3:0]  M_AXI_AWCACHE = 4'h0;
  logic [2:0]  M_AXI_AWPROT = 3'h0;
  logic [3:0]  M_AXI_AWQOS = 4'h0;
  logic        M_AXI_AWUSER = 1'b0;
  logic        M_AXI_AWVALID = 1'b0;
  logic        M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA = 32'h0;
  logic [3:0]  M_AXI_WSTRB = 4'h0;
  logic        M_AXI_WLAST = 1'b0;
  logic        M_AXI_WUSER = 1'b0;
  logic        M_AXI_WVALID = 1'b0;
  logic        M_AXI_WREADY;
  logic        M_AXI_BID;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BUSER;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY = 1'b1;
  logic        M_AXI_ARID = 1'b0;
  logic [31:0] M_AXI_ARADDR = 32'h0;
  logic [7:0]  M_AXI_ARLEN = 8'h0;
  logic [2:0]  M_AXI_ARSIZE = 3'd2;
  logic [1:0]  M_AXI_ARBURST = 2'b01;
  logic [1:0]  M_AXI_ARLOCK = 2'b00;
  logic [3:0]  M_AXI_ARCACHE = 4'h0;
  logic [2:0]  M_AXI_ARPROT = 3'h0;
  logic [3:0]  M_AXI_ARQOS = 4'h0;
  logic        M_AXI_ARUSER = 1'b0;
  logic        M_AXI_ARVALID = 1'b0;
  logic        M_AXI_ARREADY;
  logic        M_AXI_RID;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RLAST;
  logic        M_AXI_RUSER;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY = 1'b1;

  axi4_slave_mem_model #(.MEM_ADDR_BITS(14)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
    .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWLOCK(M_AXI_AWLOCK),
    .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWQOS(M_AXI_AWQOS),
    .M_AXI_AWUSER(M_AXI_AWUSER), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
    .M_AXI_WUSER(M_AXI_WUSER), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BID(M_AXI_BID), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BUSER(M_AXI_BUSER),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
    .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARLOCK(M_AXI_ARLOCK),
    .M_AXI_ARCACHE(M_AXI_ARCACHE), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARQOS(M_AXI_ARQOS),
    .M_AXI_ARUSER(M_AXI_ARUSER), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RID(M_AXI_RID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RUSER(M_AXI_RUSER), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2:0]  exp_b [$];   // {id, resp}
  logic [33:0] exp_r [$];   // {id, data, last}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: B on handshake; R on every valid cycle (head is peeked while RREADY is low)
  always @(negedge ACLK) begin
    logic [2:0]  eb;
    logic [33:0] er;
    if (M_AXI_BVALID && M_AXI_BREADY) begin
      if (exp_b.size() == 0) begin
        check("b_unexpected", 64'(M_AXI_BVALID), 64'd0);
      end else begin
        eb = exp_b.pop_front();
        check("b_resp", 64'({M_AXI_BID, M_AXI_BRESP, M_AXI_BUSER}), 64'({eb, 1'b0}));
      end
    end
    if (M_AXI_RVALID) begin
      if (exp_r.size() == 0) begin
        check("r_unexpected", 64'(M_AXI_RVALID), 64'd0);
      end else begin
        if (M_AXI_RREADY) er = exp_r.pop_front();
        else              er = exp_r[0];
        check(M_AXI_RREADY ? "r_beat" : "r_held",
              64'({M_AXI_RID, M_AXI_RDATA, M_AXI_RLAST, M_AXI_RRESP, M_AXI_RUSER}),
              64'({er, 2'b00, 1'b0}));
      end
    end
  end

  function automatic logic sel_ready(input int which);
    case (which)
      0:       return M_AXI_AWREADY;
      1:       return M_AXI_ARREADY;
      default: return M_AXI_WREADY;
    endcase
  endfunction

  // Called at posedge+1 with valid already driven; returns at posedge+1 after the handshake edge
  task automatic wait_ready(input int which, input string name);
    int n = 0;
    @(negedge ACLK);
    while (!sel_ready(which) && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    if (n >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: ready never seen, required 1", name);
    end
    @(posedge ACLK); #1;
  endtask

  task automatic wait_left(input int is_read, input int target, input string name);
    int n = 0;
    while (((is_read != 0) ? exp_r.size() : exp_b.size()) != target && n < 300) begin
      @(negedge ACLK); #1;
      n++;
    end
    if (n >= 300) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: responses outstanding, required %0d left", name, target);
    end
  endtask

  task automatic do_write(input logic id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [31:0] d [0:3],
                          input logic [3:0] strb, input logic [3:0] wl, input logic [1:0] resp);
    @(posedge ACLK); #1;
    exp_b.push_back({id, resp});
    M_AXI_AWID = id; M_AXI_AWADDR = addr; M_AXI_AWLEN = len; M_AXI_AWBURST = burst;
    M_AXI_AWVALID = 1'b1;
    wait_ready(0, "aw");
    M_AXI_AWVALID = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      M_AXI_WDATA = d[b]; M_AXI_WSTRB = strb; M_AXI_WLAST = wl[b]; M_AXI_WVALID = 1'b1;
      wait_ready(2, "w");
    end
    M_AXI_WVALID = 1'b0; M_AXI_WLAST = 1'b0;
    wait_left(0, 0, "b");
  endtask

  task automatic do_read(input logic id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [31:0] d [0:3], input int stall);
    @(posedge ACLK); #1;
    for (int b = 0; b <= int'(len); b++) begin
      exp_r.push_back({id, d[b], (b == int'(len)) ? 1'b1 : 1'b0});
    end
    M_AXI_ARID = id; M_AXI_ARADDR = addr; M_AXI_ARLEN = len; M_AXI_ARBURST = burst;
    M_AXI_RREADY = 1'b1; M_AXI_ARVALID = 1'b1;
    wait_ready(1, "ar");
    M_AXI_ARVALID = 1'b0;
    if (stall >= 0) begin
      wait_left(1, int'(len) + 1 - stall, "r_pre");
      @(posedge ACLK); #1 M_AXI_RREADY = 1'b0;
      repeat (2) @(posedge ACLK);
      #1 M_AXI_RREADY = 1'b1;
    end
    wait_left(1, 0, "r");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_outputs", 64'({M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_ARREADY, M_AXI_RVALID}), 64'd0);
    @(posedge ACLK); #1 ARESETN = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    check("rst_release", 64'({M_AXI_AWREADY, M_AXI_ARREADY}), 64'b11);

    // Single write then read, ID echoed
    do_write(1'b1, 32'h800, 8'd0, 2'b01, '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0}, 4'hF, 4'b0001, 2'b00);
    do_read (1'b1, 32'h800, 8'd0, 2'b01, '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0}, -1);

    // Byte strobes: lanes 0 and 2 updated
    do_write(1'b0, 32'h10, 8'd0, 2'b01, '{32'h11223344, 32'h0, 32'h0, 32'h0}, 4'hF, 4'b0001, 2'b00);
    do_write(1'b0, 32'h10, 8'd0, 2'b01, '{32'hAABBCCDD, 32'h0, 32'h0, 32'h0}, 4'b0101, 4'b0001, 2'b00);
    do_read (1'b0, 32'h10, 8'd0, 2'b01, '{32'h11BB33DD, 32'h0, 32'h0, 32'h0}, -1);

    // INCR burst with a two-cycle RREADY stall on the second beat
    do_write(1'b1, 32'h100, 8'd3, 2'b01, '{32'd1, 32'd2, 32'd3, 32'd4}, 4'hF, 4'b1000, 2'b00);
    do_read (1'b1, 32'h100, 8'd3, 2'b01, '{32'd1, 32'd2, 32'd3, 32'd4}, 1);

    // WLAST early, then WLAST missing on the final beat: SLVERR, data still written
    do_write(1'b0, 32'h200, 8'd1, 2'b01, '{32'hA0, 32'hA1, 32'h0, 32'h0}, 4'hF, 4'b0011, 2'b10);
    do_read (1'b0, 32'h200, 8'd1, 2'b01, '{32'hA0, 32'hA1, 32'h0, 32'h0}, -1);
    do_write(1'b1, 32'h208, 8'd1, 2'b01, '{32'hB0, 32'hB1, 32'h0, 32'h0}, 4'hF, 4'b0000, 2'b10);
    do_read (1'b1, 32'h208, 8'd1, 2'b01, '{32'hB0, 32'hB1, 32'h0, 32'h0}, -1);

    // Aliasing above 2^14 bytes
    do_write(1'b0, 32'h4000, 8'd0, 2'b01, '{32'hCAFEF00D, 32'h0, 32'h0, 32'h0}, 4'hF, 4'b0001, 2'b00);
    do_read (1'b0, 32'h0, 8'd0, 2'b01, '{32'hCAFEF00D, 32'h0, 32'h0, 32'h0}, -1);

    // FIXED burst: one word, last write wins; FIXED read repeats it
    do_write(1'b1, 32'h300, 8'd2, 2'b00, '{32'd5, 32'd6, 32'd7, 32'h0}, 4'hF, 4'b0100, 2'b00);
    do_read (1'b1, 32'h300, 8'd0, 2'b01, '{32'd7, 32'h0, 32'h0, 32'h0}, -1);
    do_read (1'b0, 32'h300, 8'd2, 2'b00, '{32'd7, 32'd7, 32'd7, 32'h0}, -1);

    // WRAP-encoded burst crossing the top of RAM wraps to word 0
    do_write(1'b0, 32'h3FFC, 8'd1, 2'b10, '{32'h77, 32'h88, 32'h0, 32'h0}, 4'hF, 4'b0010, 2'b00);
    do_read (1'b0, 32'h3FFC, 8'd1, 2'b01, '{32'h77, 32'h88, 32'h0, 32'h0}, -1);
    do_read (1'b1, 32'h0, 8'd0, 2'b01, '{32'h88, 32'h0, 32'h0, 32'h0}, -1);

    // Reset in the middle of a stalled read burst
    @(posedge ACLK); #1;
    exp_r.push_back({1'b1, 32'd1, 1'b0});
    exp_r.push_back({1'b1, 32'd2, 1'b0});
    M_AXI_ARID = 1'b1; M_AXI_ARADDR = 32'h100; M_AXI_ARLEN = 8'd3; M_AXI_ARBURST = 2'b01;
    M_AXI_RREADY = 1'b0; M_AXI_ARVALID = 1'b1;
    wait_ready(1, "ar_rst");
    M_AXI_ARVALID = 1'b0;
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1'b0;
    @(negedge ACLK);
    check("rst_mid_burst", 64'({M_AXI_RVALID, M_AXI_BVALID, M_AXI_AWREADY, M_AXI_ARREADY}), 64'd0);
    exp_r.delete();
    @(posedge ACLK); #1 ARESETN = 1'b1; M_AXI_RREADY = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    check("rst_mid_release", 64'({M_AXI_AWREADY, M_AXI_ARREADY, M_AXI_RVALID}), 64'b110);

    // RAM survives reset
    do_read (1'b0, 32'h800, 8'd0, 2'b01, '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0}, -1);

    repeat (4) @(posedge ACLK);
    check("queues_drained", 64'(exp_b.size() + exp_r.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi4_slave_mem_model.md
Name: axi4_slave_mem_model

Overview:
- Synthesizable-style AXI4 slave memory model; responds to a 32-bit AXI4 master such as the RV32IM core's external bus port.
- Backs single-beat and burst transfers with a word-addressed RAM.
- Write and read channels run as independent state machines, each with one outstanding transaction.
- Memory contents are not cleared by reset, so the bench can preload it before or during simulation.

Parameters:
- MEM_ADDR_BITS, 14, byte-address bits decoded; RAM holds 2^(MEM_ADDR_BITS-2) 32-bit words; upper address bits ignored (aliasing).

Ports:
- ACLK  in  1  clock, rising edge
- ARESETN  in  1  asynchronous active-low reset
- M_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWLOCK/AWCACHE/AWPROT/AWQOS/AWUSER  in  1/32/8/3/2/1/4/3/4/1  write address
- M_AXI_AWVALID in 1; M_AXI_AWREADY out 1
- M_AXI_WDATA/WSTRB/WLAST/WUSER/WVALID  in  32/4/1/1/1  write data; M_AXI_WREADY out 1
- M_AXI_BID out 1; M_AXI_BRESP out 2; M_AXI_BUSER out 1; M_AXI_BVALID out 1; M_AXI_BREADY in 1
- M_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARLOCK/ARCACHE/ARPROT/ARQOS/ARUSER  in  1/32/8/3/2/2/4/3/4/1  read address
- M_AXI_ARVALID in 1; M_AXI_ARREADY out 1
- M_AXI_RID out 1; M_AXI_RDATA out 32; M_AXI_RRESP out 2; M_AXI_RLAST out 1; M_AXI_RUSER out 1; M_AXI_RVALID out 1; M_AXI_RREADY in 1

Behaviour:
- Reset (ARESETN low, async): all outputs 0, both FSMs IDLE, counters cleared; RAM untouched. Reset mid-burst aborts the burst silently.
- Ignored inputs: SIZE, LOCK, CACHE, PROT, QOS, USER.
- Fixed outputs: BUSER=RUSER=0.
- Addressing: word index = addr[MEM_ADDR_BITS-1:2]; addr[1:0] ignored.
- Burst addressing: FIXED (00) keeps the address; INCR (01) and WRAP (10, treated as INCR) add 4 per beat, wrapping modulo the RAM size.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: AWREADY=1; on AWVALID, capture ID, address, LEN, BURST; clear beat count and error flag; go to W_DATA. AWREADY falls the next cycle.
  - W_DATA: WREADY=1. Each WVALID&WREADY writes the bytes enabled by WSTRB[i] (byte i = WDATA[8i+7:8i]) at the current word, then advances the address.
  - Burst end: the burst ends on the beat where count==LEN. WLAST mismatch on any beat (high early, or low on the final beat) sets the error flag. Early WLAST does not end the burst.
  - W_RESP: BVALID=1, BID=captured ID, BRESP=2'b10 (SLVERR) if error else 2'b00. Hold until BREADY, then W_IDLE.
  - Minimum write latency: AW accept to BVALID = LEN+2 cycles with WVALID always high.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: ARREADY=1; on ARVALID, capture ID, address, LEN, BURST; go to R_DATA.
  - R_DATA: RVALID=1 starting the cycle after AR accept. RDATA is combinational from RAM[current word]. RID=captured ID, RRESP=00, RLAST=(count==LEN).
  - Each RVALID&RREADY advances address and count. The beat with RLAST returns to R_IDLE.
  - RVALID, RDATA and RLAST stay stable while RREADY is low.
- Simultaneous read/write to the same word: the write commits at the clock edge; a read beat in that same cycle returns old data, and later beats return new data.
- AW and AR accepted in the same cycle: both proceed independently.

Optional Feature:
- AXI_SLAVE_RSTALL_EN defined: R_DATA inserts one idle cycle (RVALID=0) after every accepted beat. Throughput is 1 beat per 2 cycles; data, order and RLAST are unchanged.
- Not defined: back-to-back beats when RREADY is held high.

Decomposition:
- Package axi4_slave_pkg:
  - resp constants OKAY=2'b00, SLVERR=2'b10
  - burst constants FIXED/INCR/WRAP
  - enums for the write and read FSM states
- One natural sub-module: axi4_burst_addr_gen (next-address calculation, beat counter, last-beat flag), instantiated once per channel.

Test Plan:
- Reset: assert ARESETN low mid read burst → RVALID, BVALID, AWREADY, ARREADY all 0. Release → AWREADY=ARREADY=1 next cycle.
- Single write, then read: write 0xDEADBEEF to 0x800 with AWLEN=0, WSTRB=F, WLAST=1 → BRESP=00 with BID echoed. Read 0x800 → RDATA=0xDEADBEEF, RLAST=1.
- Byte strobe: write 0x11223344 to 0x10, then 0xAABBCCDD with WSTRB=0101 → read returns 0x11BB33DD.
- INCR burst: write LEN=3 at 0x100 with data 1,2,3,4 → read LEN=3 returns 1,2,3,4, RLAST only on beat 4. Deassert RREADY for 2 cycles at beat 2 → data held stable.
- WLAST error: LEN=1 burst with WLAST high on beat 1 → BRESP=10, and both beats still written.
- Address alias: write to 0x4000 with MEM_ADDR_BITS=14 → read of 0x0 returns the same data. FIXED burst with LEN=2 → all beats hit one word, last write wins.
